// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation controller: hall synchronise/debounce, start-up blanking,
// dead-time on every pattern change, PWM-gated high sides and a latched invalid-hall fault.
module bldc_commutation_ctrl #(
    parameter int PWM_BITS = 11,
    parameter int DEADTIME = 24,
    parameter int DEBOUNCE = 8,
    parameter int STARTUP  = 2000
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic                iENABLE,
    input  logic                iDIR,
    input  logic [PWM_BITS-1:0] iDUTY,
    input  logic [2:0]          iHALL,
    output logic [5:0]          oPHASES,
    output logic                oFAULT,
    output logic                oRUNNING,
    output logic [15:0]         oCOMM_CNT
);

    localparam int DbW    = $clog2(DEBOUNCE + 1);
    localparam int BlankW = $clog2(STARTUP + 1);
    localparam int DeadW  = $clog2(DEADTIME + 1);

    typedef enum logic [2:0] {
        stIdle,
        stStartup,
        stDead,
        stRun,
        stFault
    } tState;

    tState               state;
    tState               stateNext;
    logic [2:0]          hallMeta;
    logic [2:0]          hallSync;
    logic [2:0]          hallCand;
    logic [DbW-1:0]      stableCnt;
    logic [2:0]          hallDb;
    logic                hallValid;
    logic [2:0]          curHall;
    logic                curDir;
    logic [BlankW-1:0]   blankCnt;
    logic [DeadW-1:0]    deadCnt;
    logic [15:0]         commCnt;
    logic [PWM_BITS-1:0] pwmCnt;
    logic                pwmOn;
    logic                loadPattern;
    logic                bumpComm;
    logic [5:0]          phasesNext;

    function automatic logic [5:0] commPattern(input logic [2:0] hall, input logic dir);
        logic [5:0] fwd;
        case (hall)
            3'b101:  fwd = 6'b100100;
            3'b100:  fwd = 6'b100001;
            3'b110:  fwd = 6'b001001;
            3'b010:  fwd = 6'b011000;
            3'b011:  fwd = 6'b010010;
            3'b001:  fwd = 6'b000110;
            default: fwd = 6'b000000;
        endcase
        // Reverse rotation swaps the high and low switch of every phase.
        return dir ? {fwd[4], fwd[5], fwd[2], fwd[3], fwd[0], fwd[1]} : fwd;
    endfunction

    // A code is accepted once the synchronised halls have held it for DEBOUNCE cycles.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            hallMeta  <= 3'b000;
            hallSync  <= 3'b000;
            hallCand  <= 3'b000;
            stableCnt <= '0;
            hallDb    <= 3'b000;
        end else begin
            hallMeta <= iHALL;
            hallSync <= hallMeta;
            if (hallSync != hallCand) begin
                hallCand  <= hallSync;
                stableCnt <= '0;
            end else if (stableCnt == DbW'(DEBOUNCE - 1)) begin
                hallDb <= hallCand;
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

    assign hallValid = (hallDb != 3'b000) && (hallDb != 3'b111);
    assign pwmOn     = (pwmCnt < iDUTY);

    // State register and the counters that follow it.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state    <= stIdle;
            curHall  <= 3'b000;
            curDir   <= 1'b0;
            blankCnt <= '0;
            deadCnt  <= '0;
            commCnt  <= '0;
            pwmCnt   <= '0;
            oPHASES  <= 6'b000000;
        end else begin
            // NOTE: oPHASES is registered from the next state so drives drop in the same cycle the FSM leaves RUN.
            state   <= stateNext;
            pwmCnt  <= pwmCnt + 1'b1;
            oPHASES <= phasesNext;
            if (loadPattern) begin
                curHall <= hallDb;
                curDir  <= iDIR;
            end
            blankCnt <= (state == stStartup && stateNext == stStartup) ? blankCnt + 1'b1 : '0;
            deadCnt  <= (state == stDead && stateNext == stDead && !loadPattern) ? deadCnt + 1'b1 : '0;
            if (bumpComm) begin
                commCnt <= commCnt + 1'b1;
            end else if (state == stIdle && iENABLE) begin
                commCnt <= '0;
            end
        end
    end

    // Next-state logic; branch order encodes the disable > invalid > hall > direction priority.
    always_comb begin
        stateNext   = state;
        loadPattern = 1'b0;
        bumpComm    = 1'b0;
        case (state)
            stIdle: begin
                if (iENABLE) stateNext = stStartup;
            end
            stStartup: begin
                if (!iENABLE) begin
                    stateNext = stIdle;
                end else if (blankCnt == BlankW'(STARTUP)) begin
                    if (hallValid) begin
                        stateNext   = stDead;
                        loadPattern = 1'b1;
                    end else begin
                        stateNext = stFault;
                    end
                end
            end
            stDead, stRun: begin
                if (!iENABLE) begin
                    stateNext = stIdle;
                end else if (!hallValid) begin
                    stateNext = stFault;
                end else if (hallDb != curHall) begin
                    stateNext   = stDead;
                    loadPattern = 1'b1;
                    bumpComm    = 1'b1;
                end else if (iDIR != curDir) begin
                    stateNext   = stDead;
                    loadPattern = 1'b1;
                end else if (state == stDead && deadCnt == DeadW'(DEADTIME - 1)) begin
                    stateNext = stRun;
                end
            end
            stFault: begin
                if (!iENABLE) stateNext = stIdle;
            end
            default: stateNext = stIdle;
        endcase
    end

    // Output decode: only RUN drives, high sides chopped by the PWM compare.
    always_comb begin
        phasesNext = 6'b000000;
        if (stateNext == stRun) begin
            phasesNext = commPattern(curHall, curDir) & {pwmOn, 1'b1, pwmOn, 1'b1, pwmOn, 1'b1};
        end
    end

    assign oFAULT    = (state == stFault);
    assign oRUNNING  = (state == stRun) || (state == stDead);
    assign oCOMM_CNT = commCnt;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Self-checking bench for bldc_commutation_ctrl: directed scenarios plus random hall/dir/duty
// traffic, compared every cycle against a cycle-level behavioural model.
module tb_bldc_commutation_ctrl;

    localparam int PWM_BITS = 11;
    localparam int DEADTIME = 24;
    localparam int DEBOUNCE = 8;
    localparam int STARTUP  = 2000;
    localparam int PERIOD   = 42;

    logic                wCLK24 = 1'b0;
    logic                rst;
    logic                en;
    logic                dir;
    logic [PWM_BITS-1:0] duty;
    logic [2:0]          hall;
    logic [5:0]          phases;
    logic                fault;
    logic                running;
    logic [15:0]         commCnt;

    int tests = 0;
    int fails = 0;

    always #(PERIOD / 2) wCLK24 = ~wCLK24;

    bldc_commutation_ctrl #(
        .PWM_BITS(PWM_BITS),
        .DEADTIME(DEADTIME),
        .DEBOUNCE(DEBOUNCE),
        .STARTUP (STARTUP)
    ) dut (
        .iCLK     (wCLK24),
        .iRESET   (rst),
        .iENABLE  (en),
        .iDIR     (dir),
        .iDUTY    (duty),
        .iHALL    (hall),
        .oPHASES  (phases),
        .oFAULT   (fault),
        .oRUNNING (running),
        .oCOMM_CNT(commCnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {MIdle, MStartup, MDead, MRun, MFault} tModelState;

    function automatic logic [5:0] refPattern(input logic [2:0] h, input logic d);
        logic [5:0] tbl [8];
        logic [5:0] p;
        logic [5:0] r;
        tbl    = '{default: 6'b000000};
        tbl[5] = 6'b100100;
        tbl[4] = 6'b100001;
        tbl[6] = 6'b001001;
        tbl[2] = 6'b011000;
        tbl[3] = 6'b010010;
        tbl[1] = 6'b000110;
        p = tbl[h];
        r = p;
        if (d) begin
            for (int k = 0; k < 3; k++) begin
                r[2*k+1] = p[2*k];
                r[2*k]   = p[2*k+1];
            end
        end
        return r;
    endfunction

    function automatic bit validHall(input logic [2:0] h);
        return (h != 3'b000) && (h != 3'b111);
    endfunction

    tModelState mState;
    int         blankLeft;
    int         deadLeft;
    logic [2:0] mCur;
    logic       mDir;
    logic [15:0] mComm;
    int         mPwm;
    logic [2:0] mDb;
    logic [5:0] mPhases;
    logic [2:0] win[$];
    bit         modelValid = 1'b0;
    logic [2:0] oldDb;
    bit         gate;
    bit         same;

    always @(posedge wCLK24) begin
        if (rst) begin
            mState     = MIdle;
            blankLeft  = 0;
            deadLeft   = 0;
            mCur       = 3'b000;
            mDir       = 1'b0;
            mComm      = 16'd0;
            mPwm       = 0;
            mDb        = 3'b000;
            mPhases    = 6'b000000;
            win        = '{3'b000, 3'b000, 3'b000};
            modelValid = 1'b1;
        end else if (modelValid) begin
            oldDb = mDb;
            gate  = (mPwm < int'(duty));
            case (mState)
                MIdle: begin
                    if (en) begin
                        mState    = MStartup;
                        blankLeft = STARTUP;
                        mComm     = 16'd0;
                    end
                end
                MStartup: begin
                    if (!en) mState = MIdle;
                    else if (blankLeft == 0) begin
                        if (validHall(oldDb)) begin
                            mState   = MDead;
                            mCur     = oldDb;
                            mDir     = dir;
                            deadLeft = DEADTIME - 1;
                        end else begin
                            mState = MFault;
                        end
                    end else blankLeft--;
                end
                MDead, MRun: begin
                    if (!en) mState = MIdle;
                    else if (!validHall(oldDb)) mState = MFault;
                    else if (oldDb != mCur) begin
                        mCur     = oldDb;
                        mDir     = dir;
                        mComm    = mComm + 16'd1;
                        mState   = MDead;
                        deadLeft = DEADTIME - 1;
                    end else if (dir != mDir) begin
                        mDir     = dir;
                        mState   = MDead;
                        deadLeft = DEADTIME - 1;
                    end else if (mState == MDead) begin
                        if (deadLeft == 0) mState = MRun;
                        else deadLeft--;
                    end
                end
                MFault: begin
                    if (!en) mState = MIdle;
                end
                default: mState = MIdle;
            endcase
            mPhases = (mState == MRun) ? (refPattern(mCur, mDir) & (gate ? 6'b111111 : 6'b010101)) : 6'b000000;
            mPwm    = (mPwm + 1) % (1 << PWM_BITS);
            // Debounced hall = value of the last DEBOUNCE+1 samples seen two flops late.
            win.push_back(hall);
            if (win.size() > DEBOUNCE + 3) void'(win.pop_front());
            if (win.size() == DEBOUNCE + 3) begin
                same = 1'b1;
                for (int k = 1; k <= DEBOUNCE; k++) if (win[k] != win[0]) same = 1'b0;
                if (same) mDb = win[0];
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge wCLK24) begin
        if (modelValid) begin
            check("phases", 32'(phases), 32'(mPhases));
            check("fault", 32'(fault), 32'(mState == MFault));
            check("running", 32'(running), 32'(mState == MRun || mState == MDead));
            check("comm_cnt", 32'(commCnt), 32'(mComm));
            check("hl_overlap", 32'(phases & (phases >> 1) & 6'b010101), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge wCLK24);
    endtask

    task automatic waitFirstDrive(output int zeros);
        int cnt;
        for (cnt = 1; cnt <= 3000; cnt++) begin
            @(negedge wCLK24);
            if (phases != 6'b000000) break;
        end
        zeros = cnt - 1;
    endtask

    task automatic countZeros(input int n, output int zeros);
        zeros = 0;
        repeat (n) begin
            @(negedge wCLK24);
            if (phases == 6'b000000) zeros++;
        end
    endtask

    task automatic checkPat(input string name, input logic [5:0] lit);
        check({name, "_low"}, 32'(phases & 6'b010101), 32'(lit & 6'b010101));
        check({name, "_high"}, 32'(phases & ~lit), 32'd0);
    endtask

    initial begin
        #(PERIOD * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros;
        int ahLow;
        int hiOn;
        int pick;
        logic [2:0] rotSeq [5];
        logic [5:0] rotPat [5];
        logic [2:0] validCodes [6];

        rotSeq     = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        rotPat     = '{6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
        validCodes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

        rst  = 1'b1;
        en   = 1'b0;
        dir  = 1'b0;
        duty = '0;
        hall = 3'b101;
        tick(3);
        check("reset_phases", 32'(phases), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_comm", 32'(commCnt), 32'd0);
        rst = 1'b0;
        tick(20);

        // Start-up blanking and dead-time before the first drive.
        duty = 11'd2047;
        en   = 1'b1;
        waitFirstDrive(zeros);
        check("startup_zero_cycles", 32'(zeros), 32'(1 + STARTUP + DEADTIME));
        checkPat("startup_pattern", 6'b100100);
        ahLow = 0;
        repeat (2048) begin
            @(negedge wCLK24);
            if (!phases[5]) ahLow++;
        end
        check("ah_low_per_period", 32'(ahLow), 32'd1);

        // Forward rotation.
        for (int i = 0; i < 5; i++) begin
            hall = rotSeq[i];
            countZeros(500, zeros);
            check($sformatf("rot_dead_%0d", i), 32'(zeros), 32'(DEADTIME));
            checkPat($sformatf("rot_pat_%0d", i), rotPat[i]);
        end
        check("rot_comm", 32'(commCnt), 32'd5);

        // Short glitch is filtered.
        hall = 3'b011;
        tick(5);
        hall = 3'b001;
        countZeros(100, zeros);
        check("glitch_no_dead", 32'(zeros), 32'd0);
        check("glitch_comm", 32'(commCnt), 32'd5);
        checkPat("glitch_pat", 6'b000110);

        // Direction change re-enters dead-time without counting.
        hall = 3'b100;
        tick(200);
        dir = 1'b1;
        countZeros(200, zeros);
        check("dir_dead", 32'(zeros), 32'(DEADTIME));
        checkPat("dir_pat", 6'b010010);
        check("dir_comm", 32'(commCnt), 32'd6);

        // Zero duty: high sides never on, low sides follow the table.
        duty = '0;
        hiOn = 0;
        repeat (2500) begin
            @(negedge wCLK24);
            if ((phases & 6'b101010) != 6'b000000) hiOn++;
        end
        check("duty0_high_on", 32'(hiOn), 32'd0);
        checkPat("duty0_pat", 6'b010010);

        // Invalid hall latches the fault until enable drops.
        duty = 11'd1024;
        hall = 3'b111;
        tick(50);
        check("fault_set", 32'(fault), 32'd1);
        check("fault_phases", 32'(phases), 32'd0);
        hall = 3'b101;
        tick(50);
        check("fault_held", 32'(fault), 32'd1);
        en = 1'b0;
        tick(1);
        check("fault_cleared", 32'(fault), 32'd0);
        check("fault_idle", 32'(running), 32'd0);

        // Reset in the middle of RUN restarts the full blanking.
        dir = 1'b0;
        en  = 1'b1;
        waitFirstDrive(zeros);
        check("restart_zero_cycles", 32'(zeros), 32'(1 + STARTUP + DEADTIME));
        hall = 3'b100;
        tick(100);
        check("pre_reset_comm", 32'(commCnt), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrun_reset_phases", 32'(phases), 32'd0);
        check("midrun_reset_comm", 32'(commCnt), 32'd0);
        check("midrun_reset_running", 32'(running), 32'd0);
        waitFirstDrive(zeros);
        check("post_reset_zero_cycles", 32'(zeros), 32'(1 + STARTUP + DEADTIME));

        // Random traffic against the model.
        for (int it = 0; it < 150; it++) begin
            if (fault) begin
                en = 1'b0;
                tick(1);
                en = 1'b1;
            end
            pick = int'($urandom_range(0, 99));
            if (pick < 60) hall = validCodes[$urandom_range(0, 5)];
            else if (pick < 70) dir = ~dir;
            else if (pick < 80) duty = PWM_BITS'($urandom);
            else if (pick < 84) hall = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
            else if (pick < 90) begin
                en = 1'b0;
                tick($urandom_range(1, 4));
                en = 1'b1;
            end else if (pick < 92) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) tick($urandom_range(1, 12));
            else tick($urandom_range(20, 400));
        end
        tick(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
